// File: rtl/kbd_char_fifo.sv
// Keyboard character FIFO between the scan-to-ASCII decoder and the CPU bus.
// Supports pop/peek/status/flush reads, backspace editing and overflow policy.
module kbd_char_fifo #(
   parameter int                DATA_W    = 8,
   parameter int                DEPTH     = 16,
   parameter int                AW        = 4,
   parameter bit                OVERWRITE = 1'b0,
   parameter bit                BS_EN     = 1'b1,
   parameter logic [DATA_W-1:0] BS_CODE   = 8'h08
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              char_valid,
   input  logic [DATA_W-1:0] char_data,
   input  logic              cpu_rd,
   input  logic [1:0]        cpu_addr,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [AW:0]       count,
   output logic              empty,
   output logic              full,
   output logic              overflow
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;

   logic              is_bs;
   logic              is_push;
   logic              do_pop;
   logic              do_flush;
   logic              bs_act;
   logic              push_acc;
   logic              push_ovr;
   logic              ovw_adv;
   logic [AW:0]       cnt_next;
   logic [DATA_W-1:0] head;
   logic [DATA_W-1:0] status_word;

   assign empty       = (count == '0);
   assign full        = (count == FULL_CNT);
   assign head        = empty ? '0 : mem[rd_ptr];
   assign status_word = DATA_W'({overflow, full, empty, count});

   // All decisions use the occupancy at the start of the cycle; a pop in the
   // same cycle frees a slot for a push into a full FIFO.
   always_comb begin
      is_bs    = char_valid && BS_EN && (char_data == BS_CODE);
      is_push  = char_valid && !is_bs;
      do_flush = cpu_rd && (cpu_addr == 2'd3);
      do_pop   = cpu_rd && (cpu_addr == 2'd0) && !empty;
      bs_act   = is_bs && !do_flush &&
                 (do_pop ? (count > (AW+1)'(1)) : !empty);
      push_acc = is_push && !do_flush && (!full || do_pop || OVERWRITE);
      push_ovr = is_push && !do_flush && full && !do_pop;
      ovw_adv  = push_ovr && OVERWRITE;

      cnt_next = count;
      if (push_acc && !ovw_adv) cnt_next = cnt_next + (AW+1)'(1);
      if (do_pop)               cnt_next = cnt_next - (AW+1)'(1);
      if (bs_act)               cnt_next = cnt_next - (AW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         if (cpu_rd) begin
            case (cpu_addr)
               2'd0, 2'd1: cpu_rdata <= head;
               2'd2:       cpu_rdata <= status_word;
               default:    cpu_rdata <= '0;
            endcase
         end

         if (do_flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
         end else begin
            count <= cnt_next;
            if (push_acc)
               wr_ptr <= wr_ptr + AW'(1);
            else if (bs_act)
               wr_ptr <= wr_ptr - AW'(1);
            if (do_pop || ovw_adv)
               rd_ptr <= rd_ptr + AW'(1);
            if (push_ovr)
               overflow <= 1'b1;
         end
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (!clr && push_acc)
         mem[wr_ptr] <= char_data;
   end

endmodule

// File: tb/tb_kbd_char_fifo.sv
// Bench for kbd_char_fifo: drop and overwrite variants side by side, checked
// every cycle against a queue-based model plus directed expectations.
module tb_kbd_char_fifo;

   logic       clk = 1'b0;
   logic       clr;
   logic       char_valid;
   logic [7:0] char_data;
   logic       cpu_rd;
   logic [1:0] cpu_addr;

   logic [7:0] rdata [2];
   logic [4:0] cnt   [2];
   logic       emp   [2];
   logic       ful   [2];
   logic       ovf   [2];

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mq    [2][$];
   logic       m_ovf [2];
   logic [7:0] m_rd  [2];

   always #5 clk = ~clk;

   kbd_char_fifo #(.OVERWRITE(1'b0)) u_drop (
      .clk(clk), .clr(clr), .char_valid(char_valid), .char_data(char_data),
      .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_rdata(rdata[0]),
      .count(cnt[0]), .empty(emp[0]), .full(ful[0]), .overflow(ovf[0]));

   kbd_char_fifo #(.OVERWRITE(1'b1)) u_ovw (
      .clk(clk), .clr(clr), .char_valid(char_valid), .char_data(char_data),
      .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_rdata(rdata[1]),
      .count(cnt[1]), .empty(emp[1]), .full(ful[1]), .overflow(ovf[1]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Queue model: pop from the front, then apply the keyboard event.
   task automatic model_step(input int i, input bit ow);
      int n;
      if (clr) begin
         mq[i].delete();
         m_ovf[i] = 1'b0;
         m_rd[i]  = 8'h00;
         return;
      end
      n = mq[i].size();
      if (cpu_rd) begin
         case (cpu_addr)
            2'd0, 2'd1: m_rd[i] = (n > 0) ? mq[i][0] : 8'h00;
            2'd2:       m_rd[i] = {m_ovf[i], n == 16, n == 0, 5'(n)};
            default:    m_rd[i] = 8'h00;
         endcase
      end
      if (cpu_rd && cpu_addr == 2'd3) begin
         mq[i].delete();
         m_ovf[i] = 1'b0;
         return;
      end
      if (cpu_rd && cpu_addr == 2'd0 && n > 0)
         void'(mq[i].pop_front());
      if (char_valid) begin
         if (char_data == 8'h08) begin
            if (mq[i].size() > 0) void'(mq[i].pop_back());
         end else if (mq[i].size() < 16) begin
            mq[i].push_back(char_data);
         end else begin
            m_ovf[i] = 1'b1;
            if (ow) begin
               void'(mq[i].pop_front());
               mq[i].push_back(char_data);
            end
         end
      end
   endtask

   task automatic cycle(input logic cv, input logic [7:0] cd, input logic rd,
                        input logic [1:0] a, input logic c);
      char_valid = cv;
      char_data  = cd;
      cpu_rd     = rd;
      cpu_addr   = a;
      clr        = c;
      @(posedge clk);
      model_step(0, 1'b0);
      model_step(1, 1'b1);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rdata%0d", i), rdata[i], m_rd[i]);
         chk($sformatf("count%0d", i), cnt[i], mq[i].size());
         chk($sformatf("empty%0d", i), emp[i], mq[i].size() == 0);
         chk($sformatf("full%0d", i), ful[i], mq[i].size() == 16);
         chk($sformatf("ovf%0d", i), ovf[i], m_ovf[i]);
      end
      char_valid = 1'b0;
      cpu_rd     = 1'b0;
      clr        = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      cycle(1'b1, d, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic rd(input logic [1:0] a);
      cycle(1'b0, 8'h00, 1'b1, a, 1'b0);
   endtask

   initial begin
      int push_pct;
      int rd_pct;
      logic [1:0] a;
      logic [7:0] d;

      clr = 1'b1; char_valid = 1'b0; char_data = 8'h00; cpu_rd = 1'b0; cpu_addr = 2'd0;
      m_ovf[0] = 1'b0; m_ovf[1] = 1'b0; m_rd[0] = 8'h00; m_rd[1] = 8'h00;
      cycle(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);

      rd(2'd0);
      chk("rst_pop_data", rdata[0], 8'h00);
      chk("rst_count", cnt[0], 5'd0);
      chk("rst_empty", emp[0], 1'b1);

      push(8'h48); push(8'h69);
      rd(2'd0); chk("hi_pop0", rdata[0], 8'h48);
      rd(2'd0); chk("hi_pop1", rdata[0], 8'h69);
      rd(2'd0); chk("hi_pop2", rdata[0], 8'h00);
      chk("hi_count", cnt[0], 5'd0);

      for (int k = 0; k < 17; k++) push(8'h41 + 8'(k));
      chk("of_full_drop", ful[0], 1'b1);
      chk("of_ovf_drop", ovf[0], 1'b1);
      chk("of_count_ovw", cnt[1], 5'd16);
      chk("of_ovf_ovw", ovf[1], 1'b1);
      for (int k = 0; k < 16; k++) begin
         rd(2'd0);
         chk("of_pop_drop", rdata[0], 8'h41 + 8'(k));
         chk("of_pop_ovw", rdata[1], 8'h42 + 8'(k));
      end
      rd(2'd3);
      chk("flush_ovf", ovf[0], 1'b0);

      push(8'h61); push(8'h62); push(8'h08);
      chk("bs_count", cnt[0], 5'd1);
      rd(2'd0); chk("bs_pop", rdata[0], 8'h61);
      push(8'h08);
      chk("bs_empty_count", cnt[0], 5'd0);

      for (int k = 0; k < 16; k++) push(8'h30 + 8'(k));
      cycle(1'b1, 8'h7a, 1'b1, 2'd0, 1'b0);
      chk("pp_full_head", rdata[0], 8'h30);
      chk("pp_full_count", cnt[0], 5'd16);
      chk("pp_full_ovf", ovf[0], 1'b0);
      chk("pp_full_ovf_ovw", ovf[1], 1'b0);
      rd(2'd2); chk("status_full", rdata[0], 8'h50);
      rd(2'd3);
      chk("flush_count", cnt[0], 5'd0);
      chk("flush_rdata", rdata[0], 8'h00);

      push(8'h55); push(8'h56); rd(2'd1);
      cycle(1'b1, 8'h57, 1'b1, 2'd0, 1'b1);
      chk("clr_count", cnt[0], 5'd0);
      chk("clr_rdata", rdata[0], 8'h00);
      chk("clr_ovf_ovw", ovf[1], 1'b0);

      for (int ph = 0; ph < 6; ph++) begin
         push_pct = (ph % 2) ? 85 : 35;
         rd_pct   = (ph % 2) ? 20 : 60;
         for (int k = 0; k < 400; k++) begin
            d = ($urandom_range(0, 99) < 15) ? 8'h08 : 8'h41 + 8'($urandom_range(0, 25));
            a = ($urandom_range(0, 99) < 4) ? 2'd3 : 2'($urandom_range(0, 2));
            cycle($urandom_range(0, 99) < push_pct, d,
                  $urandom_range(0, 99) < rd_pct, a,
                  $urandom_range(0, 299) == 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
